lcd_byte_writer: RTL and testbench
==================================

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter: POR_CYC, 750000, power-on wait (15 ms @ 50 MHz).
REQ-002 Parameter: INIT1_CYC, 205000, wait after first init nibble (4.1 ms).
REQ-003 Parameter: INIT2_CYC, 5000, wait after second init nibble (100 us).
REQ-004 Parameter: CMD_CYC, 2000, wait after normal byte, third/fourth init nibble (40 us).
REQ-005 Parameter: CLR_CYC, 82000, wait after command byte 0x01 or 0x02 (1.64 ms).
REQ-006 Parameter: GAP_CYC, 50, gap between high and low nibble (1 us).
REQ-007 Ports: clk  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-008 Ports: rst  in  1  reset, synchronous, active-high.
REQ-009 Ports: in_valid  in  1  upstream byte available.
REQ-010 Ports: in_rs  in  1  0 = command, 1 = character data.
REQ-011 Ports: in_data  in  8  byte to write.
REQ-012 Ports: in_ready  out  1  block accepts byte this cycle.
REQ-013 Ports: init_done  out  1  power-on init sequence complete.
REQ-014 Ports: sf_e  out  1  LCD/StrataFlash select, 1 = LCD.
REQ-015 Ports: lcd_e, lcd_rs, lcd_rw  out  1 each  LCD enable, register select, read/write.
REQ-016 Ports: lcd_d  out  4  LCD data nibble (DB7..DB4).

Function
REQ-017 All outputs SHALL be registered; sf_e SHALL be constant 1, lcd_rw SHALL be constant 0.
REQ-018 States SHALL be: POR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SETUP, PULSE, HOLD, GAP, POST_WAIT.
REQ-019 POR_WAIT SHALL count POR_CYC cycles with lcd_e=0, then enter init.
REQ-020 Init SHALL write nibbles 0x3, 0x3, 0x3, 0x2 (lcd_rs=0), each as one nibble strobe followed by INIT1_CYC, INIT2_CYC, CMD_CYC, CMD_CYC respectively.
REQ-021 After the fourth init wait, init_done SHALL rise and stay 1 until reset; the state SHALL become IDLE.
REQ-022 in_ready SHALL be 1 only in IDLE; a transfer occurs on a cycle where in_valid && in_ready.
REQ-023 On transfer, in_rs and in_data SHALL be latched; in_ready SHALL drop the next cycle.
REQ-024 Nibble strobe: SETUP 2 cycles (lcd_d, lcd_rs valid, lcd_e=0), PULSE 12 cycles (lcd_e=1), HOLD 1 cycle (lcd_e=0, data held).
REQ-025 High nibble in_data[7:4] first, then GAP for GAP_CYC cycles, then low nibble in_data[3:0].
REQ-026 After low-nibble HOLD, POST_WAIT SHALL last CLR_CYC if latched rs=0 and data is 0x01 or 0x02, else CMD_CYC, then return to IDLE.
REQ-027 lcd_d and lcd_rs SHALL not change while lcd_e=1.
REQ-028 Byte cycle (IDLE to IDLE) SHALL be 2+12+1+GAP_CYC+2+12+1+wait cycles; no byte SHALL be accepted or dropped during it.
REQ-029 in_valid held with changing data during a busy period SHALL have no effect; only the value at transfer is used.
REQ-030 Wait counter SHALL be 20 bits, load parameter minus 1, decrement to 0; no wrap-around.

Reset
REQ-031 rst SHALL force POR_WAIT, counter to POR_CYC-1, init_done=0, in_ready=0, lcd_e=0, lcd_rs=0, lcd_d=0, sf_e=1, lcd_rw=0.
REQ-032 rst asserted mid-strobe SHALL drop lcd_e the next cycle and restart the full power-on sequence.

Structure
REQ-033 Shared package lcd_pkg SHALL hold the state enum, default timing constants, and command codes CLR=0x01, HOME=0x02.
REQ-034 One sub-module lcd_nibble_strobe (SETUP/PULSE/HOLD timing, start/done handshake) SHALL be used for init and data nibbles.

Verification (bench overrides POR_CYC=20, INIT1_CYC=10, INIT2_CYC=5, CMD_CYC=4, CLR_CYC=30, GAP_CYC=3)
REQ-035 Release rst -> four lcd_e pulses of 12 cycles with lcd_d 3,3,3,2, init_done=1 after final wait, in_ready=1.
REQ-036 Send rs=1, data 0x48 -> lcd_d=4 then 8 on two 12-cycle pulses, lcd_rs=1, in_ready back after 4 wait cycles.
REQ-037 Send rs=0, data 0x01 -> nibbles 0, 1, POST_WAIT 30 cycles; rs=1, data 0x01 -> POST_WAIT 4 cycles.
REQ-038 in_valid held high with 0x41, 0x42, 0x43 stepped every cycle -> exactly one byte per IDLE, values at acceptance only.
REQ-039 Assert rst during second PULSE -> lcd_e=0 next cycle, init_done=0, POR sequence repeats.
REQ-040 Check on all cycles: lcd_d/lcd_rs stable while lcd_e=1; sf_e=1, lcd_rw=0 throughout.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the 4-bit HD44780-style LCD byte writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

  // Controller states. The nibble strobe reuses IDLE/SETUP/PULSE/HOLD for its
  // own phase register. The top level reuses SETUP to mean "a data nibble
  // strobe is in flight".
  typedef enum logic [3:0] {
    POR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    POST_WAIT
  } lcd_state_e;

  // Default timing at 50 MHz, in clock cycles.
  localparam int POR_CYC_DEF   = 750000;  // 15 ms power-on wait
  localparam int INIT1_CYC_DEF = 205000;  // 4.1 ms after first wake nibble
  localparam int INIT2_CYC_DEF = 5000;    // 100 us after second wake nibble
  localparam int CMD_CYC_DEF   = 2000;    // 40 us after a normal byte
  localparam int CLR_CYC_DEF   = 82000;   // 1.64 ms after clear / home
  localparam int GAP_CYC_DEF   = 50;      // 1 us between nibbles

  // Strobe shape: data set up with E low, E high, then one hold cycle.
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 12;

  // Counter widths.
  localparam int CNT_W     = 20;
  localparam int STB_CNT_W = 4;

  // Command codes that need the long post-command wait.
  localparam logic [7:0] CMD_CLR  = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;

  // Init nibbles: three wake-ups (8-bit mode), then the switch to 4-bit mode.
  localparam logic [3:0] NIB_WAKE = 4'h3;
  localparam logic [3:0] NIB_4BIT = 4'h2;

  // Clear and home are slow to execute, so they get the long settle time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && ((data == CMD_CLR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Nibble strobe: drives one 4-bit LCD write as SETUP (E low), PULSE (E high), HOLD (E low).
// Latency: o_done is high on the single HOLD cycle, SETUP_CYC+PULSE_CYC+1 cycles after i_start.
// Backpressure: i_start is honoured only while idle; the caller sequences its starts off o_done.
module lcd_nibble_strobe
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_nib,
  input  logic       i_rs,
  output logic       o_done,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [3:0] o_lcd_d
);

  lcd_state_e             r_state;
  lcd_state_e             w_next;
  logic [STB_CNT_W-1:0]   r_cnt;
  logic [STB_CNT_W-1:0]   w_cnt_nxt;
  logic                   r_lcd_e;
  logic                   r_lcd_rs;
  logic [3:0]             r_lcd_d;

  localparam logic [STB_CNT_W-1:0] L_SETUP = STB_CNT_W'(SETUP_CYC - 1);
  localparam logic [STB_CNT_W-1:0] L_PULSE = STB_CNT_W'(PULSE_CYC - 1);

  // Next phase and phase counter: each phase counts down to zero, then advances.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next    = SETUP;
          w_cnt_nxt = L_SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_next    = PULSE;
          w_cnt_nxt = L_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_next    = HOLD;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Phase register, plus E registered from the next phase so it is high exactly during PULSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lcd_e <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_lcd_e <= (w_next == PULSE);
    end
  end

  // Data and RS are captured only at start and held until the next start, so they cannot move under E.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_d  <= 4'h0;
      r_lcd_rs <= 1'b0;
    end else if ((r_state == IDLE) && i_start) begin
      r_lcd_d  <= i_nib;
      r_lcd_rs <= i_rs;
    end
  end

  assign o_done   = (r_state == HOLD);
  assign o_lcd_e  = r_lcd_e;
  assign o_lcd_rs = r_lcd_rs;
  assign o_lcd_d  = r_lcd_d;

endmodule

// File: rtl/lcd_byte_writer.sv
// LCD byte writer: power-on init of a 4-bit LCD, then writes accepted bytes as two nibble strobes.
// Latency: a byte occupies 2*(SETUP+PULSE+1) + GAP_CYC + post-wait cycles from acceptance to next ready.
// Backpressure: valid/ready; in_ready is high only when idle, and bytes offered while busy are ignored.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int POR_CYC   = POR_CYC_DEF,
  parameter int INIT1_CYC = INIT1_CYC_DEF,
  parameter int INIT2_CYC = INIT2_CYC_DEF,
  parameter int CMD_CYC   = CMD_CYC_DEF,
  parameter int CLR_CYC   = CLR_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       sf_e,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  // Counter reload values (the counter runs from N-1 down to 0, i.e. N cycles).
  localparam logic [CNT_W-1:0] L_POR   = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(INIT1_CYC - 1);
  localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(INIT2_CYC - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_CYC - 1);

  lcd_state_e       r_state;
  lcd_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic [CNT_W-1:0] w_init_wait;
  logic [1:0]       r_init_idx;
  logic             r_init_done;
  logic             r_in_ready;
  logic             r_sf_e;
  logic             r_lcd_rw;
  logic             r_low;
  logic [7:0]       r_byte;
  logic             r_rs;
  logic             w_xfer;
  logic             w_stb_start;
  logic [3:0]       w_stb_nib;
  logic             w_stb_rs;
  logic             w_stb_done;

  // Settle time after the init nibble just written: 4.1 ms, 100 us, then 40 us twice.
  assign w_init_wait = (r_init_idx == 2'd0) ? L_INIT1 :
                       (r_init_idx == 2'd1) ? L_INIT2 : L_CMD;

  lcd_nibble_strobe u_strobe (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_stb_start),
    .i_nib    (w_stb_nib),
    .i_rs     (w_stb_rs),
    .o_done   (w_stb_done),
    .o_lcd_e  (lcd_e),
    .o_lcd_rs (lcd_rs),
    .o_lcd_d  (lcd_d)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= POR_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, counter reloads and nibble strobe requests.
  always_comb begin
    w_next      = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_stb_start = 1'b0;
    w_stb_nib   = 4'h0;
    w_stb_rs    = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      POR_WAIT: begin
        if (r_cnt == '0) begin
          w_stb_start = 1'b1;
          w_stb_nib   = NIB_WAKE;
          w_next      = INIT_NIB;
        end
      end
      INIT_NIB: begin
        if (w_stb_done) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = w_init_wait;
          w_next     = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (r_cnt == '0) begin
          if (r_init_idx == 2'd3) begin
            w_next = IDLE;
          end else begin
            w_stb_start = 1'b1;
            w_stb_nib   = (r_init_idx == 2'd2) ? NIB_4BIT : NIB_WAKE;
            w_next      = INIT_NIB;
          end
        end
      end
      IDLE: begin
        if (in_valid) begin
          w_xfer      = 1'b1;
          w_stb_start = 1'b1;
          w_stb_nib   = in_data[7:4];
          w_stb_rs    = in_rs;
          w_next      = SETUP;
        end
      end
      // SETUP stands for a whole data-nibble strobe; r_low tells which nibble it is.
      SETUP: begin
        if (w_stb_done) begin
          w_cnt_load = 1'b1;
          if (!r_low) begin
            w_cnt_val = L_GAP;
            w_next    = GAP;
          end else begin
            w_cnt_val = is_slow_cmd(r_rs, r_byte) ? L_CLR : L_CMD;
            w_next    = POST_WAIT;
          end
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_stb_start = 1'b1;
          w_stb_nib   = r_byte[3:0];
          w_stb_rs    = r_rs;
          w_next      = SETUP;
        end
      end
      POST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = POR_WAIT;
      end
    endcase
  end

  // Shared wait counter: reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= L_POR;
    end else if (w_cnt_load) begin
      r_cnt <= w_cnt_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Byte latch and sequencing flags: capture the byte on transfer, and track nibble half and init step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte     <= 8'h00;
      r_rs       <= 1'b0;
      r_low      <= 1'b0;
      r_init_idx <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_byte <= in_data;
        r_rs   <= in_rs;
        r_low  <= 1'b0;
      end else if ((r_state == GAP) && w_stb_start) begin
        r_low <= 1'b1;
      end
      if ((r_state == INIT_WAIT) && w_stb_start) begin
        r_init_idx <= r_init_idx + 2'd1;
      end
    end
  end

  // Registered status outputs; init_done is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_sf_e      <= 1'b1;
      r_lcd_rw    <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_init_done <= r_init_done | (w_next == IDLE);
      r_sf_e      <= 1'b1;
      r_lcd_rw    <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign init_done = r_init_done;
  assign sf_e      = r_sf_e;
  assign lcd_rw    = r_lcd_rw;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: random bytes against a pulse-level reference of the LCD bus.
// Latency: checks init time and per-byte busy time from the timing rules.
// Backpressure: drives valid/ready, including valid held high with changing data.
module tb_lcd_byte_writer;

  localparam int POR    = 20;
  localparam int I1     = 10;
  localparam int I2     = 5;
  localparam int CMD    = 4;
  localparam int CLR    = 30;
  localparam int GAPC   = 3;
  localparam int PW     = 12;          // E-high width of every strobe
  localparam int STROBE = 2 + PW + 1;  // setup + pulse + hold

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       init_done;
  logic       sf_e;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_byte_writer #(
    .POR_CYC   (POR),
    .INIT1_CYC (I1),
    .INIT2_CYC (I2),
    .CMD_CYC   (CMD),
    .CLR_CYC   (CLR),
    .GAP_CYC   (GAPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rs     (in_rs),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .init_done (init_done),
    .sf_e      (sf_e),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d)
  );

  typedef struct {
    logic [3:0] d;
    logic       rs;
    int         w;
  } pulse_t;

  pulse_t obs_q[$];
  pulse_t exp_q[$];
  pulse_t mon_p;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus monitor: records every E pulse as (nibble, rs, width) and checks constant pins.
  logic       e_prev = 1'b0;
  logic [3:0] cur_d = 4'h0;
  logic       cur_rs = 1'b0;
  int         cur_w = 0;

  always @(negedge clk) begin
    check("sf_e", sf_e, 1);
    check("lcd_rw", lcd_rw, 0);
    if (rst) begin
      e_prev = 1'b0;
      cur_w  = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        cur_d  = lcd_d;
        cur_rs = lcd_rs;
        cur_w  = 1;
      end else if (lcd_e && e_prev) begin
        check("stable_d", lcd_d, cur_d);
        check("stable_rs", lcd_rs, cur_rs);
        cur_w++;
      end else if (!lcd_e && e_prev) begin
        mon_p.d  = cur_d;
        mon_p.rs = cur_rs;
        mon_p.w  = cur_w;
        obs_q.push_back(mon_p);
      end
      e_prev = lcd_e;
    end
  end

  // Reference model: what the bus should show for a byte, and how long the writer is busy.
  task automatic exp_nib(input logic [3:0] d, input logic rs);
    pulse_t p;
    p.d  = d;
    p.rs = rs;
    p.w  = PW;
    exp_q.push_back(p);
  endtask

  task automatic exp_byte(input logic rs, input logic [7:0] d);
    exp_nib(d[7:4], rs);
    exp_nib(d[3:0], rs);
  endtask

  function automatic int byte_len(input logic rs, input logic [7:0] d);
    int wt;
    wt = (!rs && (d == 8'h01 || d == 8'h02)) ? CLR : CMD;
    return STROBE + GAPC + STROBE + wt;
  endfunction

  task automatic compare_pulses(input string tag);
    check({tag, "_npulse"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s_rs%0d", tag, i), obs_q[i].rs, exp_q[i].rs);
      check($sformatf("%s_w%0d", tag, i), obs_q[i].w, exp_q[i].w);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1);
  endtask

  task automatic reset_and_init();
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_d", lcd_d, 0);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("init_cycles", n, POR + 4 * STROBE + I1 + I2 + 2 * CMD);
    check("init_ready", in_ready, 1);
    exp_nib(4'h3, 1'b0);
    exp_nib(4'h3, 1'b0);
    exp_nib(4'h3, 1'b0);
    exp_nib(4'h2, 1'b0);
    compare_pulses("init");
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d);
    int n;
    wait_ready();
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_rs    = 1'($urandom);
    in_data  = 8'($urandom);
    check("ready_drop", in_ready, 0);
    n = 0;
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("busy_rs%0d_%02h", rs, d), n, byte_len(rs, d));
    exp_byte(rs, d);
  endtask

  initial begin
    logic       rs;
    logic [7:0] d;
    int         accepted;
    int         k;
    int         rises;
    logic       prev_e;

    reset_and_init();

    // Directed bytes: character, then short and long commands.
    send_byte(1'b1, 8'h48);
    compare_pulses("char48");
    send_byte(1'b0, 8'h01);
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03);
    compare_pulses("cmds");

    // Random bytes, with the slow command codes drawn often.
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(rs, d);
    end
    compare_pulses("random");

    // Valid held high while data steps every cycle: one byte per idle window.
    wait_ready();
    accepted = 0;
    k = 0;
    while (accepted < 3 && k < 1000) begin
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'h41 + 8'(k % 3);
      if (in_ready) begin
        exp_byte(1'b1, in_data);
        accepted++;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("held_accepted", accepted, 3);
    wait_ready();
    compare_pulses("held");

    // Reset in the middle of the second (low-nibble) pulse.
    d = 8'($urandom);
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    rises  = 0;
    prev_e = 1'b0;
    k = 0;
    while (rises < 2 && k < 200) begin
      @(negedge clk);
      if (lcd_e && !prev_e) rises++;
      prev_e = lcd_e;
      k++;
    end
    repeat (3) @(negedge clk);
    check("mid_pulse_e", lcd_e, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_lcd_e", lcd_e, 0);
    check("rst_mid_init_done", init_done, 0);
    check("rst_mid_ready", in_ready, 0);
    exp_nib(d[7:4], 1'b1);
    compare_pulses("pre_rst");
    reset_and_init();

    send_byte(1'b1, 8'h5A);
    compare_pulses("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
